// File: rtl/dffnsre_result_checker.sv
// Result checker for the dffnsre_inst_8lut flop bank: compares gold vs DUT Q over a run of samples.
// Optional macro DFFNSRE_CHK_FIRST_FAIL_EN builds the first-failure capture registers.
module dffnsre_result_checker #(
  parameter int WIDTH       = 8,
  parameter int NUM_SAMPLES = 10,
  parameter int CNT_W       = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
  input  logic             sample,
  input  logic [WIDTH-1:0] q_gold,
  input  logic [WIDTH-1:0] q_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_mask,
  output logic             fail_seen
);

  localparam int PC_W = $clog2(WIDTH + 1);
  localparam int SUM_W = CNT_W + PC_W + 1;
  localparam logic [CNT_W-1:0] NUM_S = CNT_W'(NUM_SAMPLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + PC_W'(v[i]);
    return n;
  endfunction

  // Saturate at all-ones instead of wrapping so a large miscompare never reads as small.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_seen_q, fail_seen_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [WIDTH-1:0] diff;
`ifdef DFFNSRE_CHK_FIRST_FAIL_EN
  logic [CNT_W-1:0] first_fail_idx_q, first_fail_idx_d;
  logic [WIDTH-1:0] first_fail_mask_q, first_fail_mask_d;
`endif

  always_comb begin
    state_d        = state_q;
    fail_seen_d    = fail_seen_q;
    mismatch_cnt_d = mismatch_cnt_q;
    sample_cnt_d   = sample_cnt_q;
`ifdef DFFNSRE_CHK_FIRST_FAIL_EN
    first_fail_idx_d  = first_fail_idx_q;
    first_fail_mask_d = first_fail_mask_q;
`endif
    diff = q_gold ^ q_dut;
    case (state_q)
      IDLE, DONE: begin
        // A start here wins over a coincident sample, which is dropped.
        if (start) begin
          state_d        = RUN;
          fail_seen_d    = 1'b0;
          mismatch_cnt_d = '0;
          sample_cnt_d   = '0;
`ifdef DFFNSRE_CHK_FIRST_FAIL_EN
          first_fail_idx_d  = '0;
          first_fail_mask_d = '0;
`endif
        end
      end
      RUN: begin
        if (sample) begin
          mismatch_cnt_d = sat_add(mismatch_cnt_q, popcount(diff));
          sample_cnt_d   = sample_cnt_q + 1'b1;
          if ((diff != '0) && !fail_seen_q) begin
            fail_seen_d = 1'b1;
`ifdef DFFNSRE_CHK_FIRST_FAIL_EN
            first_fail_idx_d  = sample_cnt_q;
            first_fail_mask_d = diff;
`endif
          end
          if (sample_cnt_d == NUM_S) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    pass_d = done_d && (mismatch_cnt_d == '0);
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_seen_q    <= 1'b0;
      mismatch_cnt_q <= '0;
      sample_cnt_q   <= '0;
`ifdef DFFNSRE_CHK_FIRST_FAIL_EN
      first_fail_idx_q  <= '0;
      first_fail_mask_q <= '0;
`endif
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      fail_seen_q    <= fail_seen_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      sample_cnt_q   <= sample_cnt_d;
`ifdef DFFNSRE_CHK_FIRST_FAIL_EN
      first_fail_idx_q  <= first_fail_idx_d;
      first_fail_mask_q <= first_fail_mask_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail_seen    = fail_seen_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign sample_cnt   = sample_cnt_q;
`ifdef DFFNSRE_CHK_FIRST_FAIL_EN
  assign first_fail_idx  = first_fail_idx_q;
  assign first_fail_mask = first_fail_mask_q;
`else
  assign first_fail_idx  = '0;
  assign first_fail_mask = '0;
`endif

endmodule

// File: tb/tb_dffnsre_result_checker.sv
// Bench for dffnsre_result_checker: default instance plus a CNT_W=4/NUM_SAMPLES=3 instance, both
// driven with the same stimulus and compared every cycle against a run-level reference model.
module tb_dffnsre_result_checker;

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic       start = 1'b0;
  logic       sample = 1'b0;
  logic [7:0] q_gold = '0;
  logic [7:0] q_dut = '0;

  logic       busy0, done0, pass0, fs0;
  logic [7:0] mis0, cnt0, idx0, mask0;
  logic       busy1, done1, pass1, fs1;
  logic [3:0] mis1, cnt1, idx1;
  logic [7:0] mask1;

  int n_checks = 0;
  int n_fail = 0;

  dffnsre_result_checker u_dut0 (
    .C(C), .R(R), .start(start), .sample(sample), .q_gold(q_gold), .q_dut(q_dut),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch_cnt(mis0), .sample_cnt(cnt0),
    .first_fail_idx(idx0), .first_fail_mask(mask0), .fail_seen(fs0)
  );

  dffnsre_result_checker #(.WIDTH(8), .NUM_SAMPLES(3), .CNT_W(4)) u_dut1 (
    .C(C), .R(R), .start(start), .sample(sample), .q_gold(q_gold), .q_dut(q_dut),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(mis1), .sample_cnt(cnt1),
    .first_fail_idx(idx1), .first_fail_mask(mask1), .fail_seen(fs1)
  );

  always #5 C = ~C;

  // Reference model: 0 = idle, 1 = running, 2 = finished.
  int         ns[2] = '{10, 3};
  int         mx[2] = '{255, 15};
  int         m_st[2], m_mis[2], m_cnt[2], m_idx[2];
  bit         m_fs[2];
  logic [7:0] m_mask[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear(input int k);
    m_mis[k] = 0; m_cnt[k] = 0; m_idx[k] = 0; m_fs[k] = 0; m_mask[k] = '0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0;
      model_clear(k);
    end
  endtask

  task automatic model_step(input bit st, input bit sa, input logic [7:0] diff);
    for (int k = 0; k < 2; k++) begin
      if (m_st[k] != 1) begin
        if (st) begin
          m_st[k] = 1;
          model_clear(k);
        end
      end else if (sa) begin
        if (diff != 0 && !m_fs[k]) begin
          m_fs[k] = 1; m_idx[k] = m_cnt[k]; m_mask[k] = diff;
        end
        m_mis[k] = m_mis[k] + $countones(diff);
        if (m_mis[k] > mx[k]) m_mis[k] = mx[k];
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == ns[k]) m_st[k] = 2;
      end
    end
  endtask

  task automatic check_all();
    int e_idx[2];
    logic [7:0] e_mask[2];
    for (int k = 0; k < 2; k++) begin
`ifdef DFFNSRE_CHK_FIRST_FAIL_EN
      e_idx[k] = m_idx[k]; e_mask[k] = m_mask[k];
`else
      e_idx[k] = 0; e_mask[k] = '0;
`endif
    end
    chk("busy0", busy0, m_st[0] == 1);
    chk("done0", done0, m_st[0] == 2);
    chk("pass0", pass0, m_st[0] == 2 && m_mis[0] == 0);
    chk("fs0", fs0, m_fs[0]);
    chk("mis0", mis0, m_mis[0]);
    chk("cnt0", cnt0, m_cnt[0]);
    chk("idx0", idx0, e_idx[0]);
    chk("mask0", mask0, e_mask[0]);
    chk("busy1", busy1, m_st[1] == 1);
    chk("done1", done1, m_st[1] == 2);
    chk("pass1", pass1, m_st[1] == 2 && m_mis[1] == 0);
    chk("fs1", fs1, m_fs[1]);
    chk("mis1", mis1, m_mis[1]);
    chk("cnt1", cnt1, m_cnt[1]);
    chk("idx1", idx1, e_idx[1]);
    chk("mask1", mask1, e_mask[1]);
  endtask

  task automatic drive(input bit st, input bit sa, input logic [7:0] g, input logic [7:0] d);
    start = st; sample = sa; q_gold = g; q_dut = d;
    @(posedge C);
    model_step(st, sa, g ^ d);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    R = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge C);
    #1;
    R = 1'b0;
    check_all();
  endtask

  logic [7:0] g, dmask;

  initial begin
    model_reset();
    repeat (2) @(posedge C);
    #1;
    check_all();
    R = 1'b0;

    // All samples match.
    drive(1, 0, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) drive(0, 1, 8'hA5, 8'hA5);
    chk("am_done", done0, 1); chk("am_pass", pass0, 1); chk("am_busy", busy0, 0);
    chk("am_mis", mis0, 0); chk("am_cnt", cnt0, 10);

    // Single failure at sample index 3.
    drive(1, 0, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      g = 8'($urandom);
      drive(0, 1, g, (i == 3) ? (g ^ 8'h81) : g);
    end
    chk("sf_mis", mis0, 2); chk("sf_pass", pass0, 0); chk("sf_fs", fs0, 1);
`ifdef DFFNSRE_CHK_FIRST_FAIL_EN
    chk("sf_idx", idx0, 3); chk("sf_mask", mask0, 8'h81);
`else
    chk("sf_idx", idx0, 0); chk("sf_mask", mask0, 8'h00);
`endif

    // Every bit differs: small-counter instance saturates at 15.
    drive(1, 0, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      g = 8'($urandom);
      drive(0, 1, g, ~g);
    end
    chk("sat_mis1", mis1, 15); chk("sat_pass1", pass1, 0); chk("sat_done1", done1, 1);
    chk("sat_mis0", mis0, 80);

    // Reset mid-run, then a clean run.
    drive(1, 0, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) drive(0, 1, 8'h3C, 8'h3C);
    R = 1'b1;
    #1;
    chk("rst_busy", busy0, 0); chk("rst_cnt", cnt0, 0); chk("rst_mis", mis0, 0);
    model_reset();
    @(posedge C);
    #1;
    R = 1'b0;
    drive(1, 0, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) drive(0, 1, 8'h5A, 8'h5A);
    chk("rr_pass", pass0, 1);

    // Ignored strobes in IDLE, start during RUN, restart from DONE.
    async_reset();
    for (int i = 0; i < 4; i++) drive(0, 1, 8'hFF, 8'h00);
    chk("idle_cnt", cnt0, 0);
    drive(1, 0, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) drive(0, 1, 8'h11, 8'h11);
    drive(1, 1, 8'h11, 8'h10);
    chk("run_start_cnt", cnt0, 5); chk("run_start_mis", mis0, 1);
    for (int i = 0; i < 5; i++) drive(0, 1, 8'h22, 8'h22);
    chk("rs_done", done0, 1); chk("rs_pass", pass0, 0);
    drive(1, 1, 8'hF0, 8'h0F);
    chk("restart_cnt", cnt0, 0); chk("restart_mis", mis0, 0);
    chk("restart_done", done0, 0); chk("restart_busy", busy0, 1); chk("restart_fs", fs0, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 8'h77, 8'h77);
    chk("restart_pass", pass0, 1);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      g = 8'($urandom);
      dmask = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 199) == 0) async_reset();
      drive($urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1, g, g ^ dmask);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
